// File: rtl/cg_mem_pkg.sv
// cg_mem_pkg: shared RAM-op and CPU access state types for the system RAM arbiter
package cg_mem_pkg;
  localparam int RAM_AW = 16;
  typedef enum logic [1:0] {IDLE, ISSUED, DATA, ACK} cpu_st_t;
  typedef struct packed {
    logic              ce;
    logic              we;
    logic [RAM_AW-1:0] addr;
    logic [7:0]        data;
  } ram_op_t;
endpackage

// File: rtl/dn_fifo.sv
// dn_fifo: synchronous FIFO buffering download {addr, data} entries, with occupancy count
module dn_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 24
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + PW'(1) : wp;
      rp <= pop ? rp + PW'(1) : rp;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk_sys)
    if (push && !clr) mem[wp] <= din;
endmodule

// File: rtl/dn_ram_arbiter.sv
// dn_ram_arbiter: shares the single-port system RAM between the Z80 bus and the ioctl download FIFO
module dn_ram_arbiter
  import cg_mem_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  input  logic          dn_go,
  input  logic          dn_wr,
  input  logic [24:0]   dn_addr,
  input  logic [7:0]    dn_data,
  output logic          dn_wait,
  output logic          dn_done,
  output logic          dn_err,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = $clog2(MAX_CPU_RUN + 1);
  cpu_st_t st, st_nxt;
  ram_op_t ram_q;
  logic [CW-1:0] count, cnt_nxt;
  logic [AW+7:0] head;
  logic [RW-1:0] cpu_run;
  logic full, empty, go_q, go_rise, go_fall, addr_ok, push;
  logic cpu_cand, fifo_grant, cpu_grant, fifo_op_q, done_arm, fire;
  assign go_rise = dn_go & ~go_q;
  assign go_fall = ~dn_go & go_q;
  assign addr_ok = dn_addr[24:AW] == '0;
  assign cpu_cand = cpu_req && st == IDLE;
  // A stale head must not reach the RAM in the cycle the FIFO is being flushed
  assign fifo_grant = !empty && !go_rise && (full || cpu_run == RW'(MAX_CPU_RUN) || !cpu_cand);
  assign cpu_grant = cpu_cand && !fifo_grant;
  assign push = dn_wr && addr_ok && (!full || fifo_grant);
  assign cnt_nxt = go_rise ? '0 : count + CW'(push) - CW'(fifo_grant);
  assign fire = done_arm && empty && !fifo_op_q;
  assign ram_ce = ram_q.ce;
  assign ram_we = ram_q.we;
  assign ram_addr = ram_q.addr;
  assign ram_din = ram_q.data;
  dn_fifo #(.DEPTH(FIFO_DEPTH), .W(AW + 8)) u_fifo (
    .clk_sys(clk_sys),
    .reset(reset),
    .clr(go_rise),
    .push(push),
    .pop(fifo_grant),
    .din({dn_addr[AW-1:0], dn_data}),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    st_nxt = st;
    cpu_ack = 1'b0;
    st_nxt = st == IDLE ? (cpu_grant ? ISSUED : IDLE) : st == ISSUED ? DATA : st == DATA ? ACK : IDLE;
    cpu_ack = st == ACK;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      st <= IDLE;
      ram_q <= '0;
      cpu_dout <= '0;
      cpu_run <= '0;
      go_q <= 1'b0;
      fifo_op_q <= 1'b0;
      done_arm <= 1'b0;
      dn_done <= 1'b0;
      dn_err <= 1'b0;
      dn_wait <= 1'b0;
    end else begin
      st <= st_nxt;
      go_q <= dn_go;
      fifo_op_q <= fifo_grant;
      dn_wait <= cnt_nxt >= CW'(FIFO_DEPTH - 1);
      cpu_dout <= st == DATA ? ram_dout : cpu_dout;
      cpu_run <= (empty || fifo_grant) ? '0 : cpu_grant ? cpu_run + RW'(1) : cpu_run;
      ram_q.ce <= cpu_grant | fifo_grant;
      ram_q.we <= fifo_grant | (cpu_grant & cpu_we);
      if (fifo_grant) {ram_q.addr, ram_q.data} <= head;
      else if (cpu_grant) {ram_q.addr, ram_q.data} <= {cpu_addr, cpu_din};
      dn_err <= !go_rise && (dn_err || (dn_wr && (!addr_ok || (full && !fifo_grant))));
      dn_done <= !go_rise && fire;
      done_arm <= !go_rise && (go_fall || (done_arm && !fire));
    end
endmodule
